fpmult_rnd: RTL and testbench

Parametrised sequential floating-point multiplier with full rounding support, the successor to the fixed 16-bit multiplier. Accepts two operands of configurable exponent/fraction width through a start/ready handshake, multiplies the significands with an iterative shift-add datapath, then normalises, rounds in one of four modes, and reports range and exception flags. It sits between the operand-issue logic and the result writeback. Latency is fixed regardless of operand values.

---
 rtl/fpmult_rnd_pkg.sv | 37 +++
 rtl/fpmult_rnd_if.sv | 26 ++
 rtl/fpmult_rnd_mant_mult.sv | 85 ++++++++
 rtl/fpmult_rnd.sv | 165 ++++++++++++++++
 tb/tb_fpmult_rnd.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fpmult_rnd_pkg.sv
// Shared types and helpers for the sequential rounding FP multiplier.
// FPMULT_RADIX4_EN selects the radix-4 multiply loop (changes the iteration count only).
package fpmult_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } round_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RND,
        S_DONE
    } state_e;

    localparam int unsigned OOR_OVF = 0;
    localparam int unsigned OOR_UNF = 1;
    localparam int unsigned OOR_INX = 2;
    localparam int unsigned OOR_INV = 3;

    function automatic int unsigned exp_bias(input int unsigned e);
        return (1 << (e - 1)) - 1;
    endfunction

    // Number of multiply iterations for an (m+1)-bit significand.
    function automatic int unsigned iter_count(input int unsigned m);
`ifdef FPMULT_RADIX4_EN
        return (m + 2) / 2;
`else
        return m + 1;
`endif
    endfunction

endpackage

// File: rtl/fpmult_rnd_if.sv
// Operand/result handshake bundle between issue logic and the multiplier.
interface fpmult_rnd_if #(
    parameter int E = 8,
    parameter int M = 7
);
    localparam int W = 1 + E + M;

    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic [1:0]   round_in;
    logic         start_in;
    logic [W-1:0] p_out;
    logic [3:0]   oor_out;
    logic         valid_out;
    logic         ready_out;

    modport master (
        output x_in, y_in, round_in, start_in,
        input  p_out, oor_out, valid_out, ready_out
    );

    modport slave (
        input  x_in, y_in, round_in, start_in,
        output p_out, oor_out, valid_out, ready_out
    );
endinterface

// File: rtl/fpmult_rnd_mant_mult.sv
// Iterative unsigned (M+1)x(M+1) significand multiplier with load/step/done.
// FPMULT_RADIX4_EN: two multiplier bits per step using a precomputed 3x multiplicand.
module mant_mult
    import fpmult_pkg::*;
#(
    parameter int M = 7
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [M:0]     a_i,
    input  logic [M:0]     b_i,
    output logic           done_o,
    output logic [2*M+1:0] prod_o
);
    localparam int unsigned NITER = iter_count(M);
    localparam int unsigned PW    = 2 * M + 2;
    localparam int unsigned CW    = $clog2(NITER + 1);
`ifdef FPMULT_RADIX4_EN
    localparam int unsigned SH    = 2;
    localparam int unsigned MPW   = 2 * NITER;
`else
    localparam int unsigned SH    = 1;
    localparam int unsigned MPW   = M + 1;
`endif

    logic [PW-1:0]  acc_q;
    logic [PW-1:0]  mc_q;
    logic [MPW-1:0] mp_q;
    logic [CW-1:0]  cnt_q;
    logic [PW-1:0]  pp;
`ifdef FPMULT_RADIX4_EN
    logic [PW-1:0]  mc3_q;

    always_comb begin
        pp = '0;
        case (mp_q[1:0])
            2'd1:    pp = mc_q;
            2'd2:    pp = mc_q << 1;
            2'd3:    pp = mc3_q;
            default: pp = '0;
        endcase
    end

    // Partial products never exceed the final product, so truncated shifts are safe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mc3_q <= '0;
        end else if (load_i) begin
            mc3_q <= PW'(a_i) + (PW'(a_i) << 1);
        end else if (step_i && cnt_q != CW'(NITER)) begin
            mc3_q <= mc3_q << SH;
        end
    end
`else
    always_comb begin
        pp = mp_q[0] ? mc_q : '0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
            mc_q  <= '0;
            mp_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            mc_q  <= PW'(a_i);
            mp_q  <= MPW'(b_i);
            cnt_q <= '0;
        end else if (step_i && cnt_q != CW'(NITER)) begin
            acc_q <= acc_q + pp;
            mc_q  <= mc_q << SH;
            mp_q  <= mp_q >> SH;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // High during the step that retires the final iteration.
    assign done_o = step_i && (cnt_q == CW'(NITER - 1));
    assign prod_o = acc_q;

endmodule

// File: rtl/fpmult_rnd.sv
// Sequential FP multiplier: capture, iterative significand multiply, normalise/round/flag.
// Latency set by mant_mult; FPMULT_RADIX4_EN shortens the multiply phase.
module fpmult_rnd
    import fpmult_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 7
) (
    input logic         clk_in,
    input logic         rst_in_N,
    fpmult_rnd_if.slave bus
);
    localparam int W  = 1 + E + M;
    localparam int PW = 2 * M + 2;
    localparam int XW = E + 2;

    localparam logic signed [XW-1:0] BIAS      = XW'(exp_bias(E));
    localparam logic signed [XW-1:0] EXP_OVF   = XW'((1 << E) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO  = '0;
    localparam logic        [E-1:0]  EXP_ONES  = '1;
    localparam logic        [E-1:0]  EXP_MAXF  = {{(E-1){1'b1}}, 1'b0};
    localparam logic        [W-1:0]  QNAN      = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

    state_e      state_q, state_d;
    logic        sx_q, sy_q;
    logic [E-1:0] ex_q, ey_q;
    logic [M-1:0] fx_q, fy_q;
    round_mode_e rm_q;
    logic [W-1:0] p_q, p_d;
    logic [3:0]  oor_q, oor_d;
    logic        valid_q;

    logic        accept;
    logic        mul_done;
    logic [PW-1:0] prod;

    assign accept = (state_q == S_IDLE) && bus.start_in;

    mant_mult #(.M(M)) u_mant_mult (
        .clk_i   (clk_in),
        .rst_n_i (rst_in_N),
        .load_i  (accept),
        .step_i  (state_q == S_MUL),
        .a_i     ({1'b1, bus.x_in[M-1:0]}),
        .b_i     ({1'b1, bus.y_in[M-1:0]}),
        .done_o  (mul_done),
        .prod_o  (prod)
    );

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            p_q     <= '0;
            oor_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            ex_q    <= '0;
            ey_q    <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            rm_q    <= RNE;
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == S_RND);
            p_q     <= p_d;
            oor_q   <= oor_d;
            if (accept) begin
                sx_q <= bus.x_in[W-1];
                sy_q <= bus.y_in[W-1];
                ex_q <= bus.x_in[W-2:M];
                ey_q <= bus.y_in[W-2:M];
                fx_q <= bus.x_in[M-1:0];
                fy_q <= bus.y_in[M-1:0];
                rm_q <= round_mode_e'(bus.round_in);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_in) state_d = S_MUL;
            S_MUL:   if (mul_done)     state_d = S_RND;
            S_RND:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    assign x_zero = (ex_q == '0);
    assign y_zero = (ey_q == '0);
    assign x_inf  = (ex_q == EXP_ONES) && (fx_q == '0);
    assign y_inf  = (ey_q == EXP_ONES) && (fy_q == '0);
    assign x_nan  = (ex_q == EXP_ONES) && (fx_q != '0);
    assign y_nan  = (ey_q == EXP_ONES) && (fy_q != '0);

    logic               sgn;
    logic [PW-1:0]      norm;
    logic [M:0]         mant;
    logic               g, st, inc, away, ovf, unf;
    logic [M+1:0]       mant_r;
    logic [M-1:0]       frac;
    logic signed [XW-1:0] exp_pre, exp_f;

    // Product lies in [1,4): keep the top M+1 bits after normalising, round, renormalise.
    always_comb begin
        sgn     = sx_q ^ sy_q;
        norm    = prod[PW-1] ? prod : (prod << 1);
        mant    = norm[PW-1:M+1];
        g       = norm[M];
        st      = |norm[M-1:0];
        exp_pre = $signed(XW'(ex_q)) + $signed(XW'(ey_q)) - BIAS
                  + $signed(XW'(prod[PW-1]));
        inc = 1'b0;
        case (rm_q)
            RNE:     inc = g & (mant[0] | st);
            RTZ:     inc = 1'b0;
            RUP:     inc = ~sgn & (g | st);
            RDN:     inc = sgn & (g | st);
            default: inc = 1'b0;
        endcase
        mant_r = {1'b0, mant} + {{(M+1){1'b0}}, inc};
        exp_f  = exp_pre + $signed(XW'(mant_r[M+1]));
        frac   = mant_r[M+1] ? mant_r[M:1] : mant_r[M-1:0];
        ovf    = (exp_f >= EXP_OVF);
        unf    = (exp_f <= EXP_ZERO);
        away   = (rm_q == RNE) || (rm_q == RUP && !sgn) || (rm_q == RDN && sgn);
    end

    always_comb begin
        p_d   = p_q;
        oor_d = oor_q;
        if (state_q == S_RND) begin
            oor_d = '0;
            if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
                p_d            = QNAN;
                oor_d[OOR_INV] = 1'b1;
            end else if (x_inf || y_inf) begin
                p_d = {sgn, EXP_ONES, {M{1'b0}}};
            end else if (x_zero || y_zero) begin
                p_d = {sgn, {(W-1){1'b0}}};
            end else if (ovf) begin
                p_d            = away ? {sgn, EXP_ONES, {M{1'b0}}}
                                      : {sgn, EXP_MAXF, {M{1'b1}}};
                oor_d[OOR_OVF] = 1'b1;
                oor_d[OOR_INX] = 1'b1;
            end else if (unf) begin
                p_d            = {sgn, {(W-1){1'b0}}};
                oor_d[OOR_UNF] = 1'b1;
                oor_d[OOR_INX] = 1'b1;
            end else begin
                p_d            = {sgn, exp_f[E-1:0], frac};
                oor_d[OOR_INX] = g | st;
            end
        end
    end

    assign bus.p_out     = p_q;
    assign bus.oor_out   = oor_q;
    assign bus.valid_out = valid_q;
    assign bus.ready_out = (state_q == S_IDLE);

endmodule

// File: tb/tb_fpmult_rnd.sv
// Directed-vector bench for fpmult_rnd (E=8, M=7); expected latency follows FPMULT_RADIX4_EN.
module tb_fpmult_rnd;
    localparam int E = 8;
    localparam int M = 7;
`ifdef FPMULT_RADIX4_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 9;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    fpmult_rnd_if #(.E(E), .M(M)) bus ();

    fpmult_rnd #(.E(E), .M(M)) dut (
        .clk_in   (clk),
        .rst_in_N (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  rm;
        logic [15:0] p;
        logic [3:0]  oor;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] x, input logic [15:0] y, input logic [1:0] rm,
                       input logic [15:0] p, input logic [3:0] oor);
        vec_t v;
        v.x = x; v.y = y; v.rm = rm; v.p = p; v.oor = oor;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns the same way, idle again.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [1:0] rm,
                          output logic [15:0] p, output logic [3:0] oor, output int lat);
        bus.x_in     = x;
        bus.y_in     = y;
        bus.round_in = rm;
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        lat = 0;
        while (!bus.valid_out && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p   = bus.p_out;
        oor = bus.oor_out;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        logic [3:0]  oor;
        int          lat;
        int          nvalid;
        logic [15:0] pseen;

        bus.x_in = '0; bus.y_in = '0; bus.round_in = '0; bus.start_in = 1'b0;

        add(16'h3FC0, 16'h4000, 2'd0, 16'h4040, 4'b0000);
        add(16'h3F81, 16'h3F81, 2'd0, 16'h3F82, 4'b0100);
        add(16'h3F81, 16'h3F81, 2'd2, 16'h3F83, 4'b0100);
        add(16'h3F81, 16'h3F81, 2'd1, 16'h3F82, 4'b0100);
        add(16'hBF81, 16'h3F81, 2'd3, 16'hBF83, 4'b0100);
        add(16'hBF81, 16'h3F81, 2'd1, 16'hBF82, 4'b0100);
        add(16'h7F7F, 16'h7F7F, 2'd0, 16'h7F80, 4'b0101);
        add(16'h7F7F, 16'h7F7F, 2'd1, 16'h7F7F, 4'b0101);
        add(16'h7F7F, 16'h7F7F, 2'd2, 16'h7F80, 4'b0101);
        add(16'h7F7F, 16'h7F7F, 2'd3, 16'h7F7F, 4'b0101);
        add(16'hFF7F, 16'h7F7F, 2'd3, 16'hFF80, 4'b0101);
        add(16'hFF7F, 16'h7F7F, 2'd2, 16'hFF7F, 4'b0101);
        add(16'h0080, 16'h0080, 2'd0, 16'h0000, 4'b0110);
        add(16'h0080, 16'h0080, 2'd2, 16'h0000, 4'b0110);
        add(16'h7F80, 16'h0000, 2'd0, 16'h7FC0, 4'b1000);
        add(16'h7FC1, 16'h3F80, 2'd0, 16'h7FC0, 4'b1000);
        add(16'hFF80, 16'h4000, 2'd0, 16'hFF80, 4'b0000);
        add(16'h8000, 16'h4000, 2'd0, 16'h8000, 4'b0000);
        add(16'h3FC0, 16'h3F81, 2'd0, 16'h3FC2, 4'b0100);
        add(16'h3FC0, 16'h3F81, 2'd1, 16'h3FC1, 4'b0100);
        add(16'h3FC0, 16'h3F83, 2'd0, 16'h3FC4, 4'b0100);
        add(16'h3F92, 16'h3FE0, 2'd0, 16'h4000, 4'b0100);
        add(16'h3F92, 16'h3FE0, 2'd1, 16'h3FFF, 4'b0100);
        add(16'h7F00, 16'h3F80, 2'd0, 16'h7F00, 4'b0000);
        add(16'h7F00, 16'h4000, 2'd0, 16'h7F80, 4'b0101);
        add(16'h0080, 16'h3F80, 2'd0, 16'h0080, 4'b0000);
        add(16'h8080, 16'h3F00, 2'd0, 16'h8000, 4'b0110);

        repeat (3) @(posedge clk);
        #1;
        chk("reset.p",     32'(bus.p_out),     32'h0);
        chk("reset.oor",   32'(bus.oor_out),   32'h0);
        chk("reset.valid", 32'(bus.valid_out), 32'h0);
        chk("reset.ready", 32'(bus.ready_out), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].rm, p, oor, lat);
            chk($sformatf("v%0d.p", i),   32'(p),   32'(vecs[i].p));
            chk($sformatf("v%0d.oor", i), 32'(oor), 32'(vecs[i].oor));
            chk($sformatf("v%0d.lat", i), 32'(lat), 32'(LAT));
        end

        // start held high into MUL, operands changed meanwhile: one result from the first capture
        bus.x_in = 16'h3F81; bus.y_in = 16'h3F81; bus.round_in = 2'd0; bus.start_in = 1'b1;
        @(posedge clk); #1;
        chk("hold.ready_busy", 32'(bus.ready_out), 32'h0);
        bus.x_in = 16'h7F7F;
        nvalid = 0;
        pseen  = '0;
        for (int k = 0; k < 25; k++) begin
            bus.start_in = (k < 3);
            @(posedge clk); #1;
            if (bus.valid_out) begin
                nvalid++;
                pseen = bus.p_out;
            end
        end
        chk("hold.count", 32'(nvalid), 32'd1);
        chk("hold.p",     32'(pseen),  32'h3F82);
        chk("hold.oor",   32'(bus.oor_out), 32'h4);

        // reset pulse mid-multiply aborts the operation
        bus.x_in = 16'h7F7F; bus.y_in = 16'h7F7F; bus.round_in = 2'd0; bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.p",     32'(bus.p_out),     32'h0);
        chk("abort.oor",   32'(bus.oor_out),   32'h0);
        chk("abort.valid", 32'(bus.valid_out), 32'h0);
        chk("abort.ready", 32'(bus.ready_out), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.valid_out) nvalid++;
        end
        chk("abort.novalid", 32'(nvalid), 32'd0);
        chk("abort.p_held",  32'(bus.p_out), 32'h0);
        run_op(16'h3FC0, 16'h4000, 2'd0, p, oor, lat);
        chk("after.p",   32'(p),   32'h4040);
        chk("after.oor", 32'(oor), 32'h0);
        chk("after.lat", 32'(lat), 32'(LAT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
